spi_xfer_arb: RTL and testbench

- Shares one `spi` core (P_WIDTH-bit, single-word transfers) between P_REQ requesters, e.g. boot flash loader, CPU peripheral bus and a debug port.
- Arbitrates round-robin and muxes each requester's word and SPI mode onto the core.
- Sequences the core's tx_en/ready/rx_valid handshake, returns the received word to the granted requester and supports locked bursts.
- Sits between the requesters and the `spi` core instance, on the same clock.

---
 rtl/spi_arb_pkg.sv | 18 +
 rtl/rr_arbiter.sv | 24 ++
 rtl/spi_xfer_arb.sv | 125 ++++++++++++
 tb/tb_spi_xfer_arb.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/spi_arb_pkg.sv
// spi_arb_pkg: shared FSM state encoding, default timeout and counter sizing for spi_xfer_arb.
//    state_t       - 3-bit arbiter FSM state encoding
//    C_TIMEOUT_DEF - default abort limit in cycles
//    tmo_width()   - bits needed to count up to a given timeout value
package spi_arb_pkg;
   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_LAUNCH     = 3'd1,
      S_WAIT_START = 3'd2,
      S_WAIT_DONE  = 3'd3,
      S_WAIT_IDLE  = 3'd4,
      S_COMPLETE   = 3'd5
   } state_t;
   localparam int C_TIMEOUT_DEF = 1023;
   function automatic int tmo_width(input int t);
      return $clog2(t + 1);
   endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after a pointer.
//    i_req  [P_REQ]         request vector
//    i_ptr  [$clog2(P_REQ)] highest-priority index
//    o_gnt  [P_REQ]         one-hot grant, zero when no request
module rr_arbiter #(
   parameter int P_REQ = 2
) (
   input  logic [P_REQ-1:0]         i_req,
   input  logic [$clog2(P_REQ)-1:0] i_ptr,
   output logic [P_REQ-1:0]         o_gnt
);
   logic [2*P_REQ-1:0] w_dbl;
   logic [P_REQ-1:0]   w_rot;
   logic [P_REQ-1:0]   w_rot_gnt;
   logic [2*P_REQ-1:0] w_back;
   // Rotate so the pointer sits at bit 0, take the lowest set bit, rotate back.
   always_comb begin
      w_dbl     = {i_req, i_req} >> i_ptr;
      w_rot     = w_dbl[P_REQ-1:0];
      w_rot_gnt = w_rot & (~w_rot + P_REQ'(1));
      w_back    = {w_rot_gnt, w_rot_gnt} << i_ptr;
      o_gnt     = w_back[2*P_REQ-1:P_REQ];
   end
endmodule

// File: rtl/spi_xfer_arb.sv
// spi_xfer_arb: shares one single-word spi core between P_REQ requesters with round-robin arbitration and burst locking.
//    i_clk/i_rst                        clock, synchronous active-high reset
//    i_req/i_req_data/i_req_last        per-requester request, tx word, release-after-word flag
//    i_req_cpol/i_req_cpha              per-requester SPI mode
//    o_gnt/o_done/o_err/o_rdata/o_busy  grant, completion pulse, timeout flag, rx word, activity
//    o_spi_* / i_spi_*                  handshake with the spi core
//    Build macro SPI_ARB_FIXED_PRIO_EN: fixed priority (lowest index wins) instead of round-robin.
module spi_xfer_arb
   import spi_arb_pkg::*;
#(
   parameter int P_REQ     = 2,
   parameter int P_WIDTH   = 32,
   parameter int P_TIMEOUT = C_TIMEOUT_DEF
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic [P_REQ-1:0]           i_req,
   input  logic [P_REQ*P_WIDTH-1:0]   i_req_data,
   input  logic [P_REQ-1:0]           i_req_last,
   input  logic [P_REQ-1:0]           i_req_cpol,
   input  logic [P_REQ-1:0]           i_req_cpha,
   output logic [P_REQ-1:0]           o_gnt,
   output logic [P_REQ-1:0]           o_done,
   output logic                       o_err,
   output logic [P_WIDTH-1:0]         o_rdata,
   output logic                       o_busy,
   output logic                       o_spi_tx_en,
   output logic [P_WIDTH-1:0]         o_spi_tx_data,
   output logic                       o_spi_cpol,
   output logic                       o_spi_cpha,
   input  logic                       i_spi_ready,
   input  logic                       i_spi_rx_valid,
   input  logic [P_WIDTH-1:0]         i_spi_rx_data
);
   localparam int C_PW = $clog2(P_REQ);
   localparam int C_TW = tmo_width(P_TIMEOUT);
   state_t             r_state, w_next;
   logic [P_REQ-1:0]   r_gnt, w_arb, w_launch_gnt;
   logic [C_PW-1:0]    r_idx, w_idx;
   logic [C_TW-1:0]    r_cnt;
   logic [P_WIDTH-1:0] r_rdata, r_tx_data;
   logic               r_lock, r_err, r_cpol, r_cpha;
   logic               w_lock_hit, w_launch, w_tmo, w_tmo_abort, w_release;
`ifdef SPI_ARB_FIXED_PRIO_EN
   assign w_arb = i_req & (~i_req + P_REQ'(1));
`else
   logic [C_PW-1:0] r_ptr;
   rr_arbiter #(.P_REQ(P_REQ)) u_arb (.i_req(i_req), .i_ptr(r_ptr), .o_gnt(w_arb));
   always_ff @(posedge i_clk) begin
      if (i_rst)
         r_ptr <= '0;
      else if (r_state == S_COMPLETE && w_release)
         r_ptr <= (r_idx == C_PW'(P_REQ - 1)) ? '0 : r_idx + C_PW'(1);
   end
`endif
   always_comb begin
      w_lock_hit   = r_lock && |(i_req & r_gnt);
      w_launch_gnt = w_lock_hit ? r_gnt : w_arb;
      // Both paths wait for an idle core, so the mode only ever changes while it is idle.
      w_launch     = i_spi_ready && |w_launch_gnt;
      w_idx        = '0;
      for (int k = 0; k < P_REQ; k++)
         if (w_launch_gnt[k]) w_idx = C_PW'(k);
      w_tmo        = r_cnt == C_TW'(P_TIMEOUT);
      w_release    = r_err || i_req_last[r_idx];
      w_next       = r_state;
      unique case (r_state)
         S_IDLE:       w_next = w_launch ? S_LAUNCH : S_IDLE;
         S_LAUNCH:     w_next = S_WAIT_START;
         S_WAIT_START: w_next = !i_spi_ready ? S_WAIT_DONE : (w_tmo ? S_COMPLETE : S_WAIT_START);
         S_WAIT_DONE:  w_next = i_spi_rx_valid ? S_WAIT_IDLE : (w_tmo ? S_COMPLETE : S_WAIT_DONE);
         S_WAIT_IDLE:  w_next = i_spi_ready ? S_COMPLETE : S_WAIT_IDLE;
         S_COMPLETE:   w_next = S_IDLE;
         default:      w_next = S_IDLE;
      endcase
      // The only way from the waiting states straight to COMPLETE is a timeout.
      w_tmo_abort  = (w_next == S_COMPLETE) && (r_state == S_WAIT_START || r_state == S_WAIT_DONE);
   end
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state   <= S_IDLE;
         r_gnt     <= '0;
         r_idx     <= '0;
         r_cnt     <= '0;
         r_rdata   <= '0;
         r_tx_data <= '0;
         r_lock    <= 1'b0;
         r_err     <= 1'b0;
         r_cpol    <= 1'b0;
         r_cpha    <= 1'b0;
      end else begin
         r_state <= w_next;
         r_err   <= w_tmo_abort;
         r_cnt   <= (r_state != w_next) ? '0 : r_cnt + C_TW'(1);
         if (r_state == S_IDLE) begin
            if (r_lock && !w_lock_hit) begin
               r_lock <= 1'b0;
               r_gnt  <= '0;
            end
            if (w_launch) begin
               r_gnt     <= w_launch_gnt;
               r_idx     <= w_idx;
               r_tx_data <= i_req_data[w_idx*P_WIDTH +: P_WIDTH];
               r_cpol    <= i_req_cpol[w_idx];
               r_cpha    <= i_req_cpha[w_idx];
            end
         end
         if (r_state == S_WAIT_DONE && i_spi_rx_valid)
            r_rdata <= i_spi_rx_data;
         if (r_state == S_COMPLETE) begin
            r_lock <= !w_release;
            if (w_release) r_gnt <= '0;
         end
      end
   end
   assign o_gnt         = r_gnt;
   assign o_done        = (r_state == S_COMPLETE) ? r_gnt : '0;
   assign o_err         = r_err;
   assign o_rdata       = r_rdata;
   assign o_busy        = r_state != S_IDLE;
   assign o_spi_tx_en   = r_state == S_LAUNCH;
   assign o_spi_tx_data = r_tx_data;
   assign o_spi_cpol    = r_cpol;
   assign o_spi_cpha    = r_cpha;
endmodule

// File: tb/tb_spi_xfer_arb.sv
// tb_spi_xfer_arb: directed self-checking bench for spi_xfer_arb with a behavioural loopback spi core.
module tb_spi_xfer_arb;
   logic        clk = 1'b0, rst = 1'b1;
   logic [1:0]  req = '0, last = '0, cpol = '0, cpha = '0;
   logic [63:0] data = '0;
   logic [1:0]  o_gnt, o_done;
   logic        o_err, o_busy, tx_en, s_cpol, s_cpha;
   logic [31:0] o_rdata, tx_data;
   logic        ready = 1'b1, rx_valid = 1'b0;
   logic [31:0] rx_data = '0, core_sh = '0;
   logic        stub_dead = 1'b0, stub_hang = 1'b0;
   int          core_cnt = 0;
   int          n_chk = 0, n_fail = 0, cyc = 0, txen_cnt = 0, t_txen = 0;
   int          done_cnt = 0, bad_done = 0, mode_bad = 0;
   logic [1:0]  pmode = '0;
   int          exp_who [4] = '{0, 1, 0, 1};
   logic [31:0] exp_rd  [4] = '{32'h1111_0000, 32'h2222_0000, 32'h1111_0001, 32'h2222_0001};

   spi_xfer_arb #(.P_REQ(2), .P_WIDTH(32), .P_TIMEOUT(15)) dut (
      .i_clk(clk), .i_rst(rst), .i_req(req), .i_req_data(data), .i_req_last(last),
      .i_req_cpol(cpol), .i_req_cpha(cpha), .o_gnt(o_gnt), .o_done(o_done), .o_err(o_err),
      .o_rdata(o_rdata), .o_busy(o_busy), .o_spi_tx_en(tx_en), .o_spi_tx_data(tx_data),
      .o_spi_cpol(s_cpol), .o_spi_cpha(s_cpha), .i_spi_ready(ready),
      .i_spi_rx_valid(rx_valid), .i_spi_rx_data(rx_data));

   always #5 clk = ~clk;

   // Loopback core: busy 1 cycle after tx_en, echoes the word ~6 cycles later, idle the cycle after.
   always @(posedge clk) begin
      rx_valid <= 1'b0;
      if (core_cnt == 0) begin
         if (tx_en && !stub_dead) begin
            ready    <= 1'b0;
            core_sh  <= tx_data;
            core_cnt <= 1;
         end
      end else if (core_cnt == 6) begin
         if (!stub_hang) begin
            rx_valid <= 1'b1;
            rx_data  <= core_sh;
            core_cnt <= 7;
         end
      end else if (core_cnt == 7) begin
         ready    <= 1'b1;
         core_cnt <= 0;
      end else
         core_cnt <= core_cnt + 1;
   end

   always @(negedge clk) begin
      if (tx_en) begin
         txen_cnt++;
         t_txen = cyc;
      end
      if (o_done != 0) done_cnt++;
      if ((o_done & ~o_gnt) != 0) bad_done++;
      if (!rst && !ready && {s_cpol, s_cpha} != pmode) mode_bad++;
      pmode = {s_cpol, s_cpha};
      cyc++;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_done(output int who, output logic [31:0] rd, output logic er);
      who = -1;
      rd  = '0;
      er  = 1'b0;
      for (int i = 0; i < 300 && who < 0; i++) begin
         tick();
         if (o_done != 0) begin
            who = (o_done == 2'b01) ? 0 : (o_done == 2'b10) ? 1 : 9;
            rd  = o_rdata;
            er  = o_err;
         end
      end
   endtask

   initial begin
      int          who;
      logic [31:0] rd;
      logic        er;
      int          t0, d0;
      repeat (3) tick();
      check("rst_gnt", o_gnt, 0);
      check("rst_done_err", {o_done, o_err}, 0);
      check("rst_busy_txen", {o_busy, tx_en}, 0);
      check("rst_rdata", o_rdata, 0);
      check("rst_txdata", tx_data, 0);
      check("rst_mode", {s_cpol, s_cpha}, 0);
      rst = 1'b0;
      data[31:0] = 32'hA5A5_0001;
      last = 2'b11;
      req  = 2'b01;
      wait_done(who, rd, er);
      check("single_who", who, 0);
      check("single_rdata", rd, 32'hA5A5_0001);
      check("single_err", er, 0);
      check("single_gnt", o_gnt, 2'b01);
      req = 2'b00;
      tick();
      check("single_release", o_gnt, 0);
      check("single_txen_pulses", txen_cnt, 1);
      rst = 1'b1;
      tick();
      rst  = 1'b0;
      data = {32'h2222_0000, 32'h1111_0000};
      req  = 2'b11;
      for (int n = 0; n < 4; n++) begin
         wait_done(who, rd, er);
         check("cont_who", who, exp_who[n]);
         check("cont_rdata", rd, exp_rd[n]);
         if (who == 0) data[31:0] = data[31:0] + 1;
         else if (who == 1) data[63:32] = data[63:32] + 1;
      end
      req = 2'b00;
      tick();
      data[31:0] = 32'h3000_0000;
      req = 2'b01;
      wait_done(who, rd, er);
      check("pre_burst_who", who, 0);
      req = 2'b00;
      tick();
      last[0] = 1'b0;
      data = {32'h4444_4444, 32'h3000_0001};
      req = 2'b01;
      for (int i = 0; i < 20 && o_gnt != 2'b01; i++) tick();
      req[1] = 1'b1;
      for (int n = 0; n < 3; n++) begin
         wait_done(who, rd, er);
         check("burst_who", who, 0);
         check("burst_rdata", rd, 32'h3000_0001 + n);
         tick();
         data[31:0] = data[31:0] + 1;
         if (n == 1) last[0] = 1'b1;
         if (n == 2) req[0] = 1'b0;
      end
      wait_done(who, rd, er);
      check("burst_tail_who", who, 1);
      check("burst_tail_rdata", rd, 32'h4444_4444);
      req = 2'b00;
      tick();
      cpol = 2'b10;
      cpha = 2'b10;
      data = {32'h6666_0002, 32'h6666_0001};
      req  = 2'b11;
      wait_done(who, rd, er);
      check("mode0_who", who, 0);
      check("mode0_rdata", rd, 32'h6666_0001);
      check("mode0_mode", {s_cpol, s_cpha}, 2'b00);
      req[0] = 1'b0;
      wait_done(who, rd, er);
      check("mode1_who", who, 1);
      check("mode1_rdata", rd, 32'h6666_0002);
      check("mode1_mode", {s_cpol, s_cpha}, 2'b11);
      req = 2'b00;
      tick();
      cpol = 2'b00;
      cpha = 2'b00;
      stub_dead = 1'b1;
      last = 2'b00;
      data[31:0] = 32'h7777_7777;
      req = 2'b01;
      wait_done(who, rd, er);
      check("tmo_who", who, 0);
      check("tmo_err", er, 1);
      check("tmo_latency", cyc - t_txen, 17);
      req = 2'b00;
      tick();
      check("tmo_release", {o_gnt, o_busy}, 0);
      stub_dead = 1'b0;
      last = 2'b11;
      stub_hang = 1'b1;
      data[63:32] = 32'h5A5A_1234;
      req = 2'b10;
      t0 = txen_cnt;
      for (int i = 0; i < 20 && txen_cnt == t0; i++) tick();
      repeat (8) tick();
      check("midrst_busy_before", o_busy, 1);
      rst = 1'b1;
      tick();
      check("midrst_gnt_busy", {o_gnt, o_busy}, 0);
      check("midrst_done_err", {o_done, o_err}, 0);
      check("midrst_rdata", o_rdata, 0);
      check("midrst_txdata", tx_data, 0);
      check("midrst_mode_txen", {s_cpol, s_cpha, tx_en}, 0);
      rst = 1'b0;
      d0 = done_cnt;
      t0 = txen_cnt;
      repeat (6) tick();
      check("midrst_no_launch", txen_cnt - t0, 0);
      check("midrst_no_done", done_cnt - d0, 0);
      check("midrst_idle", o_busy, 0);
      stub_hang = 1'b0;
      wait_done(who, rd, er);
      check("post_rst_who", who, 1);
      check("post_rst_rdata", rd, 32'h5A5A_1234);
      check("post_rst_err", er, 0);
      req = 2'b00;
      tick();
      check("done_only_to_owner", bad_done, 0);
      check("mode_stable_while_busy", mode_bad, 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule
